spi_master_sequencer: RTL



---
 rtl/spi_master_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/spi_master_sequencer.sv
// Command/response buffering stage in front of spi_master: queues words,
// fires one transaction per command, and captures each received word.
module spi_master_sequencer #(
    parameter int unsigned CMD_DEPTH    = 4,
    parameter int unsigned RSP_DEPTH    = 4,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [31:0]                  cmd_data,
    input  logic [1:0]                   cmd_len,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_data,
    output logic                         start_trans,
    input  logic                         busy,
    output logic [31:0]                  tx_data,
    output logic [1:0]                   transaction_length,
    input  logic [31:0]                  rx_data,
    output logic                         active,
    output logic                         err,
    input  logic                         err_clr,
    output logic [$clog2(CMD_DEPTH):0]   cmd_count,
    output logic [$clog2(RSP_DEPTH):0]   rsp_count
);

    localparam int unsigned CPW  = $clog2(CMD_DEPTH);
    localparam int unsigned RPW  = $clog2(RSP_DEPTH);
    localparam int unsigned CCW  = CPW + 1;
    localparam int unsigned RCW  = RPW + 1;
    localparam int unsigned TMAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  len;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, CAPTURE, GAP
    } state_t;

    cmd_t             cmd_mem_q [CMD_DEPTH];
    logic [CPW-1:0]   cmd_wr_q, cmd_rd_q;
    logic [CCW-1:0]   cmd_cnt_q;
    logic [31:0]      rsp_mem_q [RSP_DEPTH];
    logic [RPW-1:0]   rsp_wr_q, rsp_rd_q;
    logic [RCW-1:0]   rsp_cnt_q;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             start_q, start_d;
    logic             active_q, active_d;
    logic             err_q, err_d;
    cmd_t             tx_q;

    logic             cmd_full, cmd_push, cmd_pop;
    logic             rsp_full, rsp_push, rsp_pop;
    logic             launch_ok;

    assign cmd_full  = (cmd_cnt_q == CCW'(CMD_DEPTH));
    assign rsp_full  = (rsp_cnt_q == RCW'(RSP_DEPTH));
    assign cmd_push  = cmd_valid & ~cmd_full;
    assign rsp_push  = (state_q == CAPTURE);
    assign rsp_pop   = (rsp_cnt_q != '0) & rsp_ready;
    assign launch_ok = (cmd_cnt_q != '0) & ~rsp_full;

    assign cmd_ready          = ~cmd_full;
    assign rsp_valid          = (rsp_cnt_q != '0);
    assign rsp_data           = rsp_mem_q[rsp_rd_q];
    assign start_trans        = start_q;
    assign tx_data            = tx_q.data;
    assign transaction_length = tx_q.len;
    assign active             = active_q;
    assign err                = err_q;
    assign cmd_count          = cmd_cnt_q;
    assign rsp_count          = rsp_cnt_q;

    // Next-state and control decode for the transaction sequencer
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cmd_pop = 1'b0;
        err_d   = err_q & ~err_clr;
        case (state_q)
            IDLE: begin
                if (launch_ok) begin
                    state_d = LAUNCH;
                    cmd_pop = 1'b1;
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
                tmr_d   = '0;
            end
            WAIT_BUSY: begin
                if (busy) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q == TW'(BUSY_TIMEOUT - 1)) begin
                    state_d = GAP;
                    tmr_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy) state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = GAP;
                tmr_d   = '0;
            end
            GAP: begin
                if (tmr_q == TW'(GAP_CYCLES - 1)) state_d = IDLE;
                else                              tmr_d   = tmr_q + TW'(1);
            end
            default: state_d = IDLE;
        endcase
        start_d  = cmd_pop;
        active_d = (state_d != IDLE);
    end

    // FSM state, timer and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
            tx_q     <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            start_q  <= start_d;
            active_q <= active_d;
            err_q    <= err_d;
            if (cmd_pop) tx_q <= cmd_mem_q[cmd_rd_q];
        end
    end

    // Command FIFO; the launch pop happens on the edge entering LAUNCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CMD_DEPTH; i++) cmd_mem_q[i] <= '0;
            cmd_wr_q  <= '0;
            cmd_rd_q  <= '0;
            cmd_cnt_q <= '0;
        end else begin
            if (cmd_push) begin
                cmd_mem_q[cmd_wr_q] <= {cmd_data, cmd_len};
                cmd_wr_q            <= cmd_wr_q + CPW'(1);
            end
            if (cmd_pop) cmd_rd_q <= cmd_rd_q + CPW'(1);
            cmd_cnt_q <= cmd_cnt_q + CCW'(cmd_push) - CCW'(cmd_pop);
        end
    end

    // Response FIFO, first-word-fall-through head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) rsp_mem_q[i] <= '0;
            rsp_wr_q  <= '0;
            rsp_rd_q  <= '0;
            rsp_cnt_q <= '0;
        end else begin
            if (rsp_push) begin
                rsp_mem_q[rsp_wr_q] <= rx_data;
                rsp_wr_q            <= rsp_wr_q + RPW'(1);
            end
            if (rsp_pop) rsp_rd_q <= rsp_rd_q + RPW'(1);
            rsp_cnt_q <= rsp_cnt_q + RCW'(rsp_push) - RCW'(rsp_pop);
        end
    end

endmodule
